// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: FSM states, CP0 register
// addresses and Status/Cause field positions.
package exc_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_TAKE    = 2'd1,
    S_HANDLER = 2'd2,
    S_RETURN  = 2'd3
  } exc_state_t;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_IM  = 8;

  localparam int CA_EXC = 2;
  localparam int CA_IP  = 8;
  localparam int CA_BD  = 31;

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder over the exception request vector.
module exc_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [4:0]         index
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = 5'(i);
      end
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Prioritised exception controller: CP0 Status/Cause/EPC, entry/return
// sequencing and fetch redirect generation.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int          NUM_SRC     = 8,
  parameter bit          VECTOR_MODE = 1'b0,
  parameter logic [31:0] VEC_STRIDE  = 32'h20
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [31:0]            exceptAddr,
  input  logic [NUM_SRC-1:0]     excReq,
  input  logic [NUM_SRC*32-1:0]  excPC,
  input  logic [NUM_SRC-1:0]     excBD,
  input  logic                   eret,
  input  logic                   cp0WrEn,
  input  logic [4:0]             cp0WrAddr,
  input  logic [31:0]            cp0WrData,
  input  logic [4:0]             cp0RdAddr,
  output logic [31:0]            cp0RdData,
  output logic                   flush,
  output logic                   redirectValid,
  output logic [31:0]            redirectPC,
  output logic [31:0]            Status,
  output logic [31:0]            Cause,
  output logic [31:0]            EPC
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  exc_state_t          state;
  logic                ie, exl, bd;
  logic [NUM_SRC-1:0]  im, pending, pend_nxt, eff_req;
  logic [4:0]          exc_code, win;
  logic                win_vld, take;
  logic [IDX_W-1:0]    win_s;
  logic [NUM_SRC-1:0][31:0] pc_arr;
  logic [31:0]         win_pc, entry_pc;
  logic                wr_status, wr_cause, wr_epc;

  assign pc_arr  = excPC;
  assign eff_req = (excReq | pending) & im;

  exc_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (
    .req   (eff_req),
    .valid (win_vld),
    .index (win)
  );

  assign take     = (state == S_RUN) && ie && !exl && win_vld;
  assign win_s    = win[IDX_W-1:0];
  assign win_pc   = excBD[win_s] ? pc_arr[win_s] - 32'd4 : pc_arr[win_s];
  assign entry_pc = VECTOR_MODE ? exceptAddr + 32'(win) * VEC_STRIDE : exceptAddr;

  assign wr_status = cp0WrEn && (cp0WrAddr == CP0_STATUS);
  assign wr_cause  = cp0WrEn && (cp0WrAddr == CP0_CAUSE) && !take;
  assign wr_epc    = cp0WrEn && (cp0WrAddr == CP0_EPC) && !take;

  // Every raw request latches as pending; only the winner being taken is cleared.
  always_comb begin
    pend_nxt = (wr_cause ? cp0WrData[CA_IP +: NUM_SRC] : pending) | excReq;
    if (take) pend_nxt[win_s] = 1'b0;
  end

  always_comb begin
    Status = '0;
    Status[ST_IE]             = ie;
    Status[ST_EXL]            = exl;
    Status[ST_IM +: NUM_SRC]  = im;
    Cause = '0;
    Cause[CA_BD]              = bd;
    Cause[CA_EXC +: 5]        = exc_code;
    Cause[CA_IP +: NUM_SRC]   = pending;
  end

  always_comb begin
    unique case (cp0RdAddr)
      CP0_STATUS: cp0RdData = Status;
      CP0_CAUSE:  cp0RdData = Cause;
      CP0_EPC:    cp0RdData = EPC;
      default:    cp0RdData = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state         <= S_RUN;
      ie            <= 1'b1;
      exl           <= 1'b0;
      im            <= '1;
      bd            <= 1'b0;
      exc_code      <= '0;
      pending       <= '0;
      EPC           <= '0;
      flush         <= 1'b0;
      redirectValid <= 1'b0;
      redirectPC    <= '0;
    end else begin
      flush         <= 1'b0;
      redirectValid <= 1'b0;
      redirectPC    <= '0;
      pending       <= pend_nxt;
      if (wr_status) begin
        ie  <= cp0WrData[ST_IE];
        exl <= cp0WrData[ST_EXL];
        im  <= cp0WrData[ST_IM +: NUM_SRC];
      end
      if (wr_epc) EPC <= cp0WrData;
      // FSM updates come last so they win over a same-edge Status write.
      unique case (state)
        S_RUN: begin
          if (take) begin
            state         <= S_TAKE;
            exl           <= 1'b1;
            exc_code      <= win;
            bd            <= excBD[win_s];
            EPC           <= win_pc;
            flush         <= 1'b1;
            redirectValid <= 1'b1;
            redirectPC    <= entry_pc;
          end
        end
        S_TAKE: state <= S_HANDLER;
        S_HANDLER: begin
          if (eret) begin
            state         <= S_RETURN;
            exl           <= 1'b0;
            flush         <= 1'b1;
            redirectValid <= 1'b1;
            redirectPC    <= EPC;
          end
        end
        S_RETURN: state <= S_RUN;
        default:  state <= S_RUN;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{1'b0, cp0WrData, win};

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a plain instance and a vectored instance share stimulus.
module tb_exc_ctrl;

  localparam int N = 8;

  logic              CLK = 1'b0;
  logic              Reset;
  logic [31:0]       exceptAddr;
  logic [N-1:0]      excReq, excBD;
  logic [N-1:0][31:0] pcs;
  logic              eret, cp0WrEn;
  logic [4:0]        cp0WrAddr, cp0RdAddr;
  logic [31:0]       cp0WrData;

  logic [31:0] rd_data, rpc, status, cause, epc;
  logic        flush, rvld;
  logic [31:0] v_rd_data, v_rpc, v_status, v_cause, v_epc;
  logic        v_flush, v_rvld;

  exc_ctrl #(.NUM_SRC(N), .VECTOR_MODE(1'b0), .VEC_STRIDE(32'h20)) dut (
    .CLK(CLK), .Reset(Reset), .exceptAddr(exceptAddr), .excReq(excReq), .excPC(pcs),
    .excBD(excBD), .eret(eret), .cp0WrEn(cp0WrEn), .cp0WrAddr(cp0WrAddr),
    .cp0WrData(cp0WrData), .cp0RdAddr(cp0RdAddr), .cp0RdData(rd_data), .flush(flush),
    .redirectValid(rvld), .redirectPC(rpc), .Status(status), .Cause(cause), .EPC(epc)
  );

  exc_ctrl #(.NUM_SRC(N), .VECTOR_MODE(1'b1), .VEC_STRIDE(32'h20)) dut_v (
    .CLK(CLK), .Reset(Reset), .exceptAddr(exceptAddr), .excReq(excReq), .excPC(pcs),
    .excBD(excBD), .eret(eret), .cp0WrEn(cp0WrEn), .cp0WrAddr(cp0WrAddr),
    .cp0WrData(cp0WrData), .cp0RdAddr(cp0RdAddr), .cp0RdData(v_rd_data), .flush(v_flush),
    .redirectValid(v_rvld), .redirectPC(v_rpc), .Status(v_status), .Cause(v_cause), .EPC(v_epc)
  );

  always #5 CLK = ~CLK;

  typedef enum int {O_FLUSH, O_RVLD, O_RPC, O_STATUS, O_CAUSE, O_EPC, O_RD, O_VRPC, O_PEND} obs_t;
  typedef struct {
    string       tag;
    obs_t        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_of(input obs_t sel);
    case (sel)
      O_FLUSH:  return {31'd0, flush};
      O_RVLD:   return {31'd0, rvld};
      O_RPC:    return rpc;
      O_STATUS: return status;
      O_CAUSE:  return cause;
      O_EPC:    return epc;
      O_RD:     return rd_data;
      O_VRPC:   return v_rpc;
      O_PEND:   return {24'd0, cause[15:8]};
      default:  return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic exp_v(input string tag, input obs_t sel, input logic [31:0] v);
    sb.push_back('{tag, sel, v});
  endtask

  // One clock; everything queued for this edge is compared just after it.
  task automatic step();
    exp_t e;
    @(posedge CLK);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs_of(e.sel), e.exp);
    end
  endtask

  // Called while observing TAKE: runs HANDLER, eret, RETURN back to RUN.
  task automatic finish_exc(input logic [31:0] ret_pc);
    exp_v("handler_flush", O_FLUSH, 32'd0);
    exp_v("handler_rpc", O_RPC, 32'd0);
    step();
    eret = 1'b1;
    exp_v("ret_flush", O_FLUSH, 32'd1);
    exp_v("ret_rvld", O_RVLD, 32'd1);
    exp_v("ret_rpc", O_RPC, ret_pc);
    step();
    eret = 1'b0;
    exp_v("run_flush", O_FLUSH, 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; exceptAddr = 32'h500; excReq = '0; excBD = '0; pcs = '0;
    eret = 1'b0; cp0WrEn = 1'b0; cp0WrAddr = '0; cp0WrData = '0; cp0RdAddr = 5'd12;
    step();
    exp_v("rst_status", O_STATUS, 32'h0000_FF01);
    exp_v("rst_cause", O_CAUSE, 32'd0);
    exp_v("rst_epc", O_EPC, 32'd0);
    exp_v("rst_flush", O_FLUSH, 32'd0);
    exp_v("rst_rvld", O_RVLD, 32'd0);
    exp_v("rst_rd_status", O_RD, 32'h0000_FF01);
    step();
    Reset = 1'b0;

    // eret outside HANDLER does nothing
    eret = 1'b1;
    exp_v("eret_run_flush", O_FLUSH, 32'd0);
    exp_v("eret_run_status", O_STATUS, 32'h0000_FF01);
    step();
    eret = 1'b0;

    // basic take and return
    pcs[2] = 32'h534; excReq = 8'h04;
    exp_v("t1_flush", O_FLUSH, 32'd1);
    exp_v("t1_rvld", O_RVLD, 32'd1);
    exp_v("t1_rpc", O_RPC, 32'h500);
    exp_v("t1_vrpc", O_VRPC, 32'h540);
    exp_v("t1_epc", O_EPC, 32'h534);
    exp_v("t1_cause", O_CAUSE, 32'h0000_0008);
    exp_v("t1_status_exl", O_STATUS, 32'h0000_FF03);
    step();
    excReq = '0;
    exp_v("t1_handler_flush", O_FLUSH, 32'd0);
    step();
    eret = 1'b1;
    exp_v("t1_ret_rpc", O_RPC, 32'h534);
    exp_v("t1_ret_flush", O_FLUSH, 32'd1);
    exp_v("t1_ret_status", O_STATUS, 32'h0000_FF01);
    step();
    eret = 1'b0;
    exp_v("t1_run_rvld", O_RVLD, 32'd0);
    step();

    // two sources: lower index wins, other pends; eret+request in HANDLER pends
    pcs[1] = 32'h100; pcs[5] = 32'h200; pcs[7] = 32'h700; excReq = 8'h22;
    exp_v("t2_cause", O_CAUSE, 32'h0000_2004);
    exp_v("t2_epc", O_EPC, 32'h100);
    step();
    excReq = '0;
    step();
    eret = 1'b1; excReq = 8'h80;
    exp_v("t2_ret_rpc", O_RPC, 32'h100);
    exp_v("t2_ret_pend", O_PEND, 32'h0000_00A0);
    step();
    eret = 1'b0; excReq = '0;
    exp_v("t2_run_flush", O_FLUSH, 32'd0);
    step();
    exp_v("t2_pend5_cause", O_CAUSE, 32'h0000_8014);
    exp_v("t2_pend5_epc", O_EPC, 32'h200);
    exp_v("t2_pend5_flush", O_FLUSH, 32'd1);
    step();
    finish_exc(32'h200);
    exp_v("t2_pend7_cause", O_CAUSE, 32'h0000_001C);
    exp_v("t2_pend7_epc", O_EPC, 32'h700);
    step();
    finish_exc(32'h700);

    // branch delay slot
    pcs[0] = 32'h450; excBD = 8'h01; excReq = 8'h01;
    exp_v("t3_epc", O_EPC, 32'h44C);
    exp_v("t3_cause", O_CAUSE, 32'h8000_0000);
    step();
    excReq = '0; excBD = '0;
    finish_exc(32'h44C);

    // vectored entry
    pcs[3] = 32'h380; excReq = 8'h08;
    exp_v("t4_rpc", O_RPC, 32'h500);
    exp_v("t4_vrpc", O_VRPC, 32'h560);
    step();
    excReq = '0;
    finish_exc(32'h380);

    // masked request pends, then is taken once unmasked
    cp0WrEn = 1'b1; cp0WrAddr = 5'd12; cp0WrData = 32'h0000_FB01; cp0RdAddr = 5'd12;
    exp_v("t5_status", O_STATUS, 32'h0000_FB01);
    exp_v("t5_rd_status", O_RD, 32'h0000_FB01);
    step();
    cp0WrEn = 1'b0; excReq = 8'h04;
    exp_v("t5_masked_flush", O_FLUSH, 32'd0);
    exp_v("t5_masked_pend", O_PEND, 32'h0000_0004);
    step();
    excReq = '0;
    cp0WrEn = 1'b1; cp0WrData = 32'h0000_FF01;
    exp_v("t5_unmask_flush", O_FLUSH, 32'd0);
    step();
    cp0WrEn = 1'b0;
    exp_v("t5_take_flush", O_FLUSH, 32'd1);
    exp_v("t5_take_cause", O_CAUSE, 32'h0000_0008);
    step();
    finish_exc(32'h534);

    // CP0 EPC write, ignored address, read of unmapped address
    cp0WrEn = 1'b1; cp0WrAddr = 5'd14; cp0WrData = 32'h1234; cp0RdAddr = 5'd14;
    exp_v("t6_epc_wr", O_EPC, 32'h1234);
    exp_v("t6_rd_epc", O_RD, 32'h1234);
    step();
    cp0WrAddr = 5'd15; cp0WrData = 32'hFFFF_FFFF; cp0RdAddr = 5'd15;
    exp_v("t6_rd_other", O_RD, 32'd0);
    exp_v("t6_epc_kept", O_EPC, 32'h1234);
    step();

    // EPC write colliding with exception entry loses
    cp0WrAddr = 5'd14; cp0WrData = 32'hDEAD_BEEF; excReq = 8'h01;
    exp_v("t7_epc_collide", O_EPC, 32'h450);
    step();
    cp0WrEn = 1'b0; excReq = '0;
    finish_exc(32'h450);

    // reset in HANDLER overrides eret and a Status write
    excReq = 8'h02;
    step();
    excReq = '0;
    step();
    Reset = 1'b1; eret = 1'b1; cp0WrEn = 1'b1; cp0WrAddr = 5'd12; cp0WrData = 32'd0;
    exp_v("t8_status", O_STATUS, 32'h0000_FF01);
    exp_v("t8_flush", O_FLUSH, 32'd0);
    exp_v("t8_cause", O_CAUSE, 32'd0);
    exp_v("t8_epc", O_EPC, 32'd0);
    step();
    Reset = 1'b0; eret = 1'b0; cp0WrEn = 1'b0;
    excReq = 8'h04;
    exp_v("t8_post_flush", O_FLUSH, 32'd1);
    exp_v("t8_post_rpc", O_RPC, 32'h500);
    step();
    excReq = '0;
    finish_exc(32'h534);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8 (1..16): number of prioritised exception sources.
REQ-002 SHALL have parameter VECTOR_MODE, default 0: 0 = single entry point, 1 = vectored entry points.
REQ-003 SHALL have parameter VEC_STRIDE, default 32'h20: byte spacing between vectored entry points.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have the following ports, clock and reset first:
- CLK  in  1  clock.
- Reset  in  1  synchronous active-high reset.
- exceptAddr  in  32  handler base address.
- excReq  in  NUM_SRC  per-source request; index 0 = highest priority.
- excPC  in  NUM_SRC*32  faulting PC per source, source i at [32i+31:32i].
- excBD  in  NUM_SRC  source i instruction is in a branch delay slot.
- eret  in  1  return-from-exception pulse.
- cp0WrEn  in  1  register write enable.
- cp0WrAddr  in  5  register write address.
- cp0WrData  in  32  register write data.
- cp0RdAddr  in  5  register read address.
- cp0RdData  out  32  combinational read data.
- flush  out  1  pipeline flush pulse.
- redirectValid  out  1  fetch redirect pulse.
- redirectPC  out  32  fetch redirect target.
- Status  out  32  Status register.
- Cause  out  32  Cause register.
- EPC  out  32  EPC register.

Function
REQ-006 Status fields SHALL be: [0] IE, [1] EXL, [8+NUM_SRC-1:8] IM; all other bits read 0.
REQ-007 Cause fields SHALL be: [31] BD, [6:2] ExcCode (winning index), [8+NUM_SRC-1:8] pending; all other bits read 0.
REQ-008 The FSM SHALL have states RUN, TAKE, HANDLER and RETURN.
REQ-009 In RUN, the effective request SHALL be (excReq | pending) & IM, qualified by IE=1 and EXL=0.
REQ-010 A non-zero effective request in RUN SHALL select the lowest set index as winner.
REQ-011 On selecting a winner the block SHALL go to TAKE.
REQ-012 At the TAKE clock edge the block SHALL set EXL=1.
REQ-013 At the TAKE clock edge the block SHALL set ExcCode to the winning index.
REQ-014 At the TAKE clock edge the block SHALL clear the winner's pending bit.
REQ-015 At the TAKE clock edge the block SHALL set pending bits for every non-winning raw request.
REQ-016 At the TAKE clock edge, EPC SHALL be excPC[win], or excPC[win]-4 when excBD[win]=1; BD SHALL be set to excBD[win].
REQ-017 While in TAKE, flush and redirectValid SHALL each be 1 for exactly one cycle (latency 1 clock from the request).
REQ-018 While in TAKE, redirectPC SHALL be exceptAddr when VECTOR_MODE=0.
REQ-019 While in TAKE, redirectPC SHALL be exceptAddr + win*VEC_STRIDE (modulo 2^32) when VECTOR_MODE=1.
REQ-020 TAKE SHALL always go to HANDLER.
REQ-021 HANDLER SHALL stay in HANDLER until eret=1, then go to RETURN.
REQ-022 RETURN SHALL clear EXL.
REQ-023 While in RETURN, flush and redirectValid SHALL each be 1 for one cycle with redirectPC=EPC.
REQ-024 RETURN SHALL always go to RUN.
REQ-025 Requests in TAKE, HANDLER or RETURN, and masked requests in RUN, SHALL set pending bits without redirecting.
REQ-026 Pending sources SHALL be taken in RUN once they are unmasked and EXL=0.
REQ-027 eret received in RUN or TAKE SHALL be ignored.
REQ-028 When eret and a request arrive together in HANDLER, eret SHALL be honoured and the request SHALL go to pending.
REQ-029 CP0 writes SHALL be applied at the clock edge to register 12 (Status), 13 (Cause; pending bits only) and 14 (EPC).
REQ-030 Writes to any other CP0 address SHALL be ignored.
REQ-031 A CP0 write to Cause or EPC in the same cycle as entry to TAKE SHALL be discarded in favour of the exception update.
REQ-032 A CP0 write to Status SHALL take effect for sampling in the following cycle.
REQ-033 cp0RdData SHALL return Status, Cause or EPC for addresses 12, 13 or 14, and 0 for any other address.
REQ-034 Outside TAKE and RETURN, flush and redirectValid SHALL be 0 and redirectPC SHALL be 0.

Reset
REQ-035 Reset SHALL set Status to IE=1, EXL=0 and IM all ones (NUM_SRC=8: 0x0000FF01).
REQ-036 Reset SHALL set Cause=0 and EPC=0.
REQ-037 Reset SHALL force the FSM to RUN and set flush=0 and redirectValid=0.
REQ-038 Reset asserted in any state SHALL override all other activity at that edge, including pending pulses and CP0 writes.

Structure
REQ-039 Package exc_ctrl_pkg SHALL hold the FSM state enum, the CP0 addresses (12, 13, 14) and the Status/Cause field positions.
REQ-040 Sub-module exc_prio_enc SHALL implement the parametrised lowest-index priority encoder, with outputs valid and index.

Verification (NUM_SRC=8, exceptAddr=0x500 unless stated)
REQ-041 Reset: Status=0x0000FF01, Cause=0, EPC=0, flush=0, redirectValid=0.
REQ-042 excReq=0x04, excPC[2]=0x534 -> next cycle flush=1, redirectPC=0x500, EPC=0x534, Cause=0x00000008; eret -> redirectPC=0x534, EXL=0.
REQ-043 excReq=0x22 -> ExcCode=1, Cause[13]=1; after eret, RUN takes source 5 (ExcCode=5, Cause[13]=0).
REQ-044 excReq=0x01, excBD=0x01, excPC[0]=0x450 -> EPC=0x44C, Cause[31]=1.
REQ-045 VECTOR_MODE=1, VEC_STRIDE=0x20, excReq=0x08 -> redirectPC=0x560.
REQ-046 Write Status=0x0000FB01, excReq=0x04 -> no redirect, Cause[10]=1; write Status=0x0000FF01 -> taken next cycle with ExcCode=2.
